// File: rtl/index_stream_provider.sv
// Issues a run of consecutive table indices under fullness back-pressure and tracks
// returned results. Optional DRAIN watchdog: define INDEX_STREAM_WATCHDOG_EN.
module index_stream_provider #(
  parameter int unsigned MEMSIZE         = 16384,
  parameter int unsigned FULLNESS_WIDTH  = 5,
  parameter int unsigned FULL_THRESHOLD  = 30,
  parameter int unsigned WATCHDOG_CYCLES = 4096,
  localparam int unsigned IW = $clog2(MEMSIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IW-1:0]             startIndex,
  input  logic [IW:0]               count,
  input  logic [FULLNESS_WIDTH-1:0] maxFullness,
  output logic [IW-1:0]             index,
  output logic                      dataAvailable,
  input  logic                      resultValid,
  output logic [IW-1:0]             checkIndex,
  output logic [IW:0]               outstanding,
  output logic                      busy,
  output logic                      done,
  output logic                      error
`ifdef INDEX_STREAM_WATCHDOG_EN
  ,
  output logic                      timeout
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] next_idx_q, next_idx_d;
  logic [IW-1:0] index_q, index_d;
  logic          dav_q, dav_d;
  logic [IW-1:0] check_q, check_d;
  logic [IW:0]   issued_q, issued_d;
  logic [IW:0]   received_q, received_d;
  logic [IW:0]   outstanding_q, outstanding_d;
  logic [IW:0]   count_q, count_d;
  logic          error_q, error_d;
  logic          issue, accept;

`ifdef INDEX_STREAM_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
`endif

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(MEMSIZE - 1)) ? '0 : v + IW'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    next_idx_d    = next_idx_q;
    index_d       = index_q;
    dav_d         = 1'b0;
    check_d       = check_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    error_d       = error_q;
    issue         = 1'b0;
    accept        = 1'b0;
`ifdef INDEX_STREAM_WATCHDOG_EN
    wd_d          = wd_q;
    timeout_d     = timeout_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          next_idx_d    = startIndex;
          check_d       = startIndex;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          count_d       = count;
          error_d       = 1'b0;
`ifdef INDEX_STREAM_WATCHDOG_EN
          wd_d          = '0;
          timeout_d     = 1'b0;
`endif
          state_d       = (count == '0) ? S_DONE : S_RUN;
        end else if (resultValid) begin
          error_d = 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        issue  = (state_q == S_RUN) && (32'(maxFullness) < FULL_THRESHOLD) &&
                 (issued_q < count_q);
        // A result with nothing outstanding is a protocol error and is not counted.
        accept = resultValid && (outstanding_q != '0);
        if (resultValid && !accept) error_d = 1'b1;
        if (issue) begin
          dav_d      = 1'b1;
          index_d    = next_idx_q;
          next_idx_d = wrap_inc(next_idx_q);
          issued_d   = issued_q + (IW+1)'(1);
          if (issued_d == count_q) state_d = S_DRAIN;
        end
        if (accept) begin
          check_d    = wrap_inc(check_q);
          received_d = received_q + (IW+1)'(1);
          if ((state_q == S_DRAIN) && (received_d == count_q)) state_d = S_DONE;
        end
        outstanding_d = issued_d - received_d;
`ifdef INDEX_STREAM_WATCHDOG_EN
        if (state_q == S_DRAIN) begin
          if (resultValid) begin
            wd_d = '0;
          end else if (wd_q == WDW'(WATCHDOG_CYCLES - 1)) begin
            wd_d      = '0;
            timeout_d = 1'b1;
            error_d   = 1'b1;
            state_d   = S_DONE;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      next_idx_q    <= '0;
      index_q       <= '0;
      dav_q         <= 1'b0;
      check_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      error_q       <= 1'b0;
`ifdef INDEX_STREAM_WATCHDOG_EN
      wd_q          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      next_idx_q    <= next_idx_d;
      index_q       <= index_d;
      dav_q         <= dav_d;
      check_q       <= check_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      error_q       <= error_d;
`ifdef INDEX_STREAM_WATCHDOG_EN
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign index         = index_q;
  assign dataAvailable = dav_q;
  assign checkIndex    = check_q;
  assign outstanding   = outstanding_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;
`ifdef INDEX_STREAM_WATCHDOG_EN
  assign timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_index_stream_provider.sv
// Directed bench for index_stream_provider with an index/checkIndex scoreboard.
`timescale 1ns/1ps
module tb_index_stream_provider;
  localparam int unsigned MEMSIZE = 16384;
  localparam int unsigned IW      = 14;
`ifdef INDEX_STREAM_WATCHDOG_EN
  localparam int unsigned WD      = 16;
`endif

  logic          clk = 1'b0;
  logic          rst, start, resultValid;
  logic [IW-1:0] startIndex;
  logic [IW:0]   count;
  logic [4:0]    maxFullness;
  logic [IW-1:0] index, checkIndex;
  logic          dataAvailable, busy, done, error;
  logic [IW:0]   outstanding;
`ifdef INDEX_STREAM_WATCHDOG_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  index_stream_provider #(
    .MEMSIZE(MEMSIZE),
    .FULLNESS_WIDTH(5),
    .FULL_THRESHOLD(30)
`ifdef INDEX_STREAM_WATCHDOG_EN
    , .WATCHDOG_CYCLES(WD)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .startIndex(startIndex), .count(count),
    .maxFullness(maxFullness), .index(index), .dataAvailable(dataAvailable),
    .resultValid(resultValid), .checkIndex(checkIndex), .outstanding(outstanding),
    .busy(busy), .done(done), .error(error)
`ifdef INDEX_STREAM_WATCHDOG_EN
    , .timeout(timeout)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_idx_q[$];
  int unsigned exp_chk_q[$];
  int unsigned last_idx;
  logic [2:0]  ret_pipe;
  int          ret_left, stall_cnt, peak, cyc, rv_cyc, c0;
  bit          seen_issue;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs after the edge, then drive inputs for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dataAvailable === 1'b1) begin
      if (exp_idx_q.size() == 0) chk("dav_extra", dataAvailable, 0);
      else begin
        last_idx = exp_idx_q.pop_front();
        chk("index", index, last_idx);
      end
      seen_issue = 1'b1;
    end else if (seen_issue && exp_idx_q.size() != 0) begin
      stall_cnt++;
      chk("index_hold", index, last_idx);
    end
    if (int'(outstanding) > peak) peak = int'(outstanding);
    ret_pipe    = {ret_pipe[1:0], dataAvailable === 1'b1};
    resultValid = 1'b0;
    if (ret_pipe[2] && ret_left > 0) begin
      ret_left--;
      resultValid = 1'b1;
      rv_cyc      = cyc;
      if (exp_chk_q.size() == 0) chk("result_extra", resultValid, 0);
      else chk("checkIndex", checkIndex, exp_chk_q.pop_front());
    end
  endtask

  task automatic do_start(input int unsigned si, input int unsigned cnt, input int rets);
    startIndex = IW'(si);
    count      = (IW+1)'(cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      exp_idx_q.push_back((si + i) % MEMSIZE);
      exp_chk_q.push_back((si + i) % MEMSIZE);
    end
    ret_left   = rets;
    ret_pipe   = '0;
    seen_issue = 1'b0;
    stall_cnt  = 0;
    peak       = 0;
    start      = 1'b1;
    tick();
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; resultValid = 1'b0; startIndex = '0; count = '0;
    maxFullness = '0; ret_left = 0; ret_pipe = '0; cyc = 0; rv_cyc = 0; c0 = 0;
    seen_issue = 1'b0; stall_cnt = 0; peak = 0; last_idx = 0;
    repeat (3) tick();
    chk("rst_index", index, 0);
    chk("rst_dav", dataAvailable, 0);
    chk("rst_checkIndex", checkIndex, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    tick();

    // Basic run: 8 indices from 0, results three cycles behind issue.
    do_start(0, 8, 8);
    chk("t1_busy", busy, 1);
    chk("t1_done_early", done, 0);
    run_until_done(40);
    chk("t1_done_latency", cyc - rv_cyc, 1);
    chk("t1_peak", peak, 3);
    chk("t1_idx_left", exp_idx_q.size(), 0);
    chk("t1_chk_left", exp_chk_q.size(), 0);
    chk("t1_final_checkIndex", checkIndex, 8);
    chk("t1_outstanding", outstanding, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_error", error, 0);
    tick();
    chk("t1_done_stays", done, 1);

    // Back-pressure: 5 cycles at threshold, then just below.
    do_start(100, 12, 12);
    repeat (3) tick();
    maxFullness = 5'd30;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_dav", dataAvailable, 0);
    end
    maxFullness = 5'd29;
    tick();
    chk("t2_resume_dav", dataAvailable, 1);
    run_until_done(60);
    chk("t2_stall_cycles", stall_cnt, 5);
    chk("t2_chk_left", exp_chk_q.size(), 0);
    chk("t2_final_checkIndex", checkIndex, 112);
    maxFullness = '0;

    // Wrap-around at the top of the table.
    do_start(MEMSIZE - 2, 4, 4);
    run_until_done(40);
    chk("t3_idx_left", exp_idx_q.size(), 0);
    chk("t3_final_checkIndex", checkIndex, 2);

    // Empty run, then a stray result.
    do_start(5, 0, 0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    repeat (3) begin
      tick();
      chk("t4_dav", dataAvailable, 0);
    end
    resultValid = 1'b1;
    tick();
    chk("t4_error", error, 1);
    chk("t4_outstanding", outstanding, 0);
    chk("t4_checkIndex", checkIndex, 5);
    tick();
    chk("t4_error_sticky", error, 1);

    // Asynchronous reset mid-run with five outstanding.
    do_start(200, 10, 0);
    chk("t5_error_cleared", error, 0);
    repeat (5) tick();
    chk("t5_outstanding", outstanding, 5);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_index", index, 0);
    chk("t5_rst_dav", dataAvailable, 0);
    chk("t5_rst_outstanding", outstanding, 0);
    chk("t5_rst_checkIndex", checkIndex, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    exp_idx_q.delete();
    exp_chk_q.delete();
    seen_issue = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle_busy", busy, 0);
    do_start(7, 2, 2);
    run_until_done(30);
    chk("t5_error", error, 0);
    chk("t5_final_checkIndex", checkIndex, 9);
    chk("t5_chk_left", exp_chk_q.size(), 0);

`ifdef INDEX_STREAM_WATCHDOG_EN
    // One result never returns: watchdog ends the run.
    do_start(0, 4, 3);
    chk("t6_timeout_cleared", timeout, 0);
    run_until_done(60);
    chk("t6_latency", cyc - c0, 22);
    chk("t6_timeout", timeout, 1);
    chk("t6_error", error, 1);
    exp_chk_q.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=%0d expected=finished", cyc);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/index_stream_provider.md
Name: index_stream_provider

Overview:
- Parametrised successor to the bench-side index provider that feeds a pipeline pack from a memory table.
- Issues a run of `count` consecutive memory indices, starting at a programmable index and wrapping modulo MEMSIZE.
- Applies back-pressure from the pack's reported fullness against a parametrised threshold.
- Tracks returned results, so the checker always knows which table entry each result belongs to, and reports run completion and protocol errors.

Parameters:
- MEMSIZE, 16384: table depth; any value >= 2; IW = $clog2(MEMSIZE).
- FULLNESS_WIDTH, 5: width of the maxFullness input.
- FULL_THRESHOLD, 30: issue allowed only while maxFullness < FULL_THRESHOLD.
- WATCHDOG_CYCLES, 4096: timeout limit, used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- startIndex  in  IW  first index of the run.
- count  in  IW+1  number of indices in the run (0..MEMSIZE).
- maxFullness  in  FULLNESS_WIDTH  pack occupancy.
- index  out  IW  current issued index; valid while dataAvailable=1.
- dataAvailable  out  1  one new index per high cycle.
- resultValid  in  1  pack produced one result this cycle.
- checkIndex  out  IW  table index of the result arriving on resultValid.
- outstanding  out  IW+1  issued minus received.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- error  out  1  sticky protocol error.
- timeout  out  1  present only with the optional feature.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Reset forces IDLE and clears every register; all outputs are 0.
- IDLE/DONE with start=1:
  - Loads nextIndex=startIndex, checkIndex=startIndex, issued=0, received=0.
  - Goes to RUN, or directly to DONE if count=0.
  - In DONE with start=0, stays in DONE; done stays high.
  - start during RUN/DRAIN is ignored.
- RUN, issue rule, evaluated at each edge: if maxFullness < FULL_THRESHOLD and issued < count, then:
  - dataAvailable <= 1, index <= nextIndex;
  - nextIndex <= (nextIndex == MEMSIZE-1) ? 0 : nextIndex+1;
  - issued++.
  - Otherwise dataAvailable <= 0 and index holds its value.
- Issue latency: one cycle from the maxFullness sample to dataAvailable.
- RUN -> DRAIN on the edge where issued reaches count. dataAvailable is 0 on all cycles after the last issue.
- Result counting (RUN and DRAIN): each cycle with resultValid=1:
  - checkIndex advances with the same wrap rule as nextIndex;
  - received++.
  - The consumer compares results against checkIndex in the same cycle as resultValid.
- DRAIN -> DONE on the edge where received reaches count.
- resultValid while outstanding=0, or while in IDLE/DONE: sets error; received and checkIndex do not change. error clears only on rst or an accepted start.
- Issue and result on the same edge: outstanding is unchanged.
- A result may arrive on the same edge as the final issue.
- outstanding = issued - received, registered; never underflows.
- Wrap-around: startIndex=MEMSIZE-2, count=4 issues MEMSIZE-2, MEMSIZE-1, 0, 1.

Optional Feature:
- Macro: INDEX_STREAM_WATCHDOG_EN.
- Defined:
  - A counter increments every cycle in DRAIN with resultValid=0 and resets on resultValid.
  - At WATCHDOG_CYCLES the block sets sticky timeout=1 and error=1 and goes to DONE.
  - timeout clears on rst or an accepted start.
- Undefined: no timeout port and no counter; DRAIN waits indefinitely.

Test Plan:
- Reset release, start, startIndex=0, count=8, maxFullness=0, results returned after 3 cycles -> index 0..7 on 8 consecutive dataAvailable cycles; checkIndex steps 0..7; done=1 one edge after the 8th result; outstanding peaks at 3.
- maxFullness=30 for 5 cycles mid-run, then 29 -> dataAvailable=0 exactly for those 5 issue cycles (shifted 1 cycle); index holds; issuing resumes the cycle after 29 is sampled.
- startIndex=16382, count=4, MEMSIZE=16384 -> index sequence 16382, 16383, 0, 1; checkIndex follows the same sequence.
- start with count=0 -> DONE next edge; dataAvailable never rises. Then a resultValid pulse -> error=1; received stays 0.
- rst asserted asynchronously mid-RUN with outstanding=5 -> all outputs 0 immediately; state IDLE; next start with count=2 runs cleanly.
- With INDEX_STREAM_WATCHDOG_EN, WATCHDOG_CYCLES=16, count=4, only 3 results returned -> timeout=1 and error=1 after 16 idle DRAIN cycles; done=1.
